// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, error causes, bank state.
// Common to the SDRAM controller and the responder model.
package sdram_pkg;

  // {ras_n,cas_n,we_n} with cs_n=0 prepended
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_BST       = 4'b0110,
    CMD_NOP       = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ACT_OPEN  = 3'd1,
    ERR_BANK_IDLE = 3'd2,
    ERR_TRCD      = 3'd3,
    ERR_NOT_IDLE  = 3'd4,
    ERR_BAD_CL    = 3'd5,
    ERR_BAD_BL    = 3'd6
  } sdram_err_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  localparam logic [12:0] MODE_RST = 13'h020;
  localparam int          RD_DEPTH = 3;

  typedef struct packed {
    logic vld;
    logic oe;
    logic cl3;
  } rd_slot_t;

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read return pipeline: tracks in-flight READs and drives dq_out/dq_oe
// on the CAS-latency edge. Data is taken from mem_rdata at issue+2.
module sdram_rd_pipe
  import sdram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_i,
  input  logic        mask_i,
  input  logic        cl3_i,
  input  logic [15:0] rdata_i,
  output logic        dq_oe_o,
  output logic [15:0] dq_out_o
);

  rd_slot_t [RD_DEPTH:1] pipe_q;
  logic [15:0]           rdata_q;
  logic [15:0]           dq_out_q;
  logic                  dq_oe_q;
  logic                  fire2, fire3;

  // CL per slot so a mode change cannot misalign reads already in flight
  always_comb begin
    fire2 = pipe_q[2].vld & ~pipe_q[2].cl3;
    fire3 = pipe_q[3].vld &  pipe_q[3].cl3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q   <= '0;
      rdata_q  <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
    end else begin
      pipe_q   <= {pipe_q[2:1], rd_slot_t'{issue_i, ~mask_i, cl3_i}};
      rdata_q  <= rdata_i;
      dq_oe_q  <= (fire2 & pipe_q[2].oe) | (fire3 & pipe_q[3].oe);
      if (fire2)      dq_out_q <= rdata_i;
      else if (fire3) dq_out_q <= rdata_q;
    end
  end

  assign dq_oe_o  = dq_oe_q;
  assign dq_out_o = dq_out_q;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes commands, tracks banks/rows/tRCD,
// maps READ/WRITE onto a simple word memory port and flags protocol errors.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 9,
  parameter int TRCD     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cs_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [1:0]                       ba,
  input  logic [ROW_BITS-1:0]              a,
  input  logic [1:0]                       dqm,
  input  logic [15:0]                      dq_in,
  output logic [15:0]                      dq_out,
  output logic                             dq_oe,
  output logic [2+ROW_BITS+COL_BITS-1:0]   mem_addr,
  output logic                             mem_we,
  output logic [1:0]                       mem_be,
  output logic [15:0]                      mem_wdata,
  input  logic [15:0]                      mem_rdata,
  output logic [12:0]                      mode_reg,
  output logic [15:0]                      refresh_cnt,
  output logic                             err,
  output logic [2:0]                       err_code
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam int TW = $clog2(TRCD + 1) + 1;

  bank_state_e [3:0]               bst_q, bst_d;
  logic [3:0][ROW_BITS-1:0]        row_q, row_d;
  logic [3:0][TW-1:0]              trcd_q, trcd_d;
  logic [12:0]                     mode_q, mode_d;
  logic [15:0]                     ref_q, ref_d;
  logic                            err_q, err_d;
  sdram_err_e                      code_q, code_d, code;
  logic [AW-1:0]                   mem_addr_q, mem_addr_d;
  logic                            mem_we_q, mem_we_d;
  logic [1:0]                      mem_be_q, mem_be_d;
  logic [15:0]                     mem_wdata_q, mem_wdata_d;

  sdram_cmd_e  cmd;
  logic        all_idle, bank_open, trcd_ok, rd_issue;
  logic [2:0]  cl;

  always_comb begin
    cmd       = cs_n ? CMD_NOP : sdram_cmd_e'({1'b0, ras_n, cas_n, we_n});
    all_idle  = 1'b1;
    for (int i = 0; i < 4; i++)
      if (bst_q[i] == BANK_ACTIVE) all_idle = 1'b0;
    cl        = mode_q[6:4];
    bank_open = (bst_q[ba] == BANK_ACTIVE);
    trcd_ok   = (int'(trcd_q[ba]) + 1) >= TRCD;

    bst_d       = bst_q;
    row_d       = row_q;
    mode_d      = mode_q;
    ref_d       = ref_q;
    err_d       = err_q;
    code_d      = code_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_be_d    = 2'b00;
    rd_issue    = 1'b0;
    code        = ERR_NONE;
    for (int i = 0; i < 4; i++)
      trcd_d[i] = (trcd_q[i] < TW'(TRCD)) ? trcd_q[i] + TW'(1) : trcd_q[i];

    case (cmd)
      CMD_ACTIVE: begin
        if (bank_open) code = ERR_ACT_OPEN;
        else begin
          bst_d[ba]  = BANK_ACTIVE;
          row_d[ba]  = a;
          trcd_d[ba] = '0;
        end
      end
      CMD_READ, CMD_WRITE: begin
        mem_addr_d = {ba, row_q[ba], a[COL_BITS-1:0]};
        if (!bank_open)                       code = ERR_BANK_IDLE;
        else if (cmd == CMD_READ &&
                 !(cl == 3'd2 || cl == 3'd3)) code = ERR_BAD_CL;
        else if (!trcd_ok)                    code = ERR_TRCD;
        if (cmd == CMD_WRITE) begin
          mem_we_d    = (dqm != 2'b11);
          mem_be_d    = ~dqm;
          mem_wdata_d = dq_in;
        end else begin
          // a late (tRCD) read is still served; idle-bank / bad-CL reads are not
          rd_issue = (code == ERR_NONE) || (code == ERR_TRCD);
        end
      end
      CMD_PRECHARGE: begin
        if (a[10]) for (int i = 0; i < 4; i++) bst_d[i] = BANK_IDLE;
        else       bst_d[ba] = BANK_IDLE;
      end
      CMD_REFRESH: begin
        if (!all_idle) code = ERR_NOT_IDLE;
        else           ref_d = ref_q + 16'd1;
      end
      CMD_LOAD_MODE: begin
        if (!all_idle) code = ERR_NOT_IDLE;
        else begin
          mode_d = 13'(a);
          if (a[2:0] != 3'b000) code = ERR_BAD_BL;
        end
      end
      default: ;
    endcase

    if (!err_q && code != ERR_NONE) begin
      err_d  = 1'b1;
      code_d = code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) bst_q[i] <= BANK_IDLE;
      row_q       <= '0;
      trcd_q      <= '0;
      mode_q      <= MODE_RST;
      ref_q       <= '0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= '0;
    end else begin
      bst_q       <= bst_d;
      row_q       <= row_d;
      trcd_q      <= trcd_d;
      mode_q      <= mode_d;
      ref_q       <= ref_d;
      err_q       <= err_d;
      code_q      <= code_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  sdram_rd_pipe u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .issue_i  (rd_issue),
    .mask_i   (dqm == 2'b11),
    .cl3_i    (cl == 3'd3),
    .rdata_i  (mem_rdata),
    .dq_oe_o  (dq_oe),
    .dq_out_o (dq_out)
  );

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign mode_reg    = mode_q;
  assign refresh_cnt = ref_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus random command streams,
// all checked cycle by cycle against a timestamp-based behavioural model.
module tb_sdram_responder;

  localparam int TRCD = 2;

  logic        clk, reset;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba, dqm;
  logic [12:0] a;
  logic [15:0] dq_in, dq_out, mem_wdata, mem_rdata, refresh_cnt;
  logic        dq_oe, mem_we, err;
  logic [23:0] mem_addr;
  logic [1:0]  mem_be;
  logic [12:0] mode_reg;
  logic [2:0]  err_code;

  sdram_responder dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .a(a), .dqm(dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mode_reg(mode_reg), .refresh_cnt(refresh_cnt),
    .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [23:0] ad);
    return ad[15:0] ^ {ad[23:16], ad[23:16]} ^ 16'h5A5A;
  endfunction

  // one-cycle-latency memory
  always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

  int total = 0, bad = 0, cyc = 0;

  // reference model state
  bit          m_open[4];
  logic [12:0] m_row[4];
  int          m_act[4];
  logic [12:0] m_mode;
  logic [15:0] m_ref;
  bit          m_err;
  logic [2:0]  m_code;
  logic [15:0] exp_dq[int];
  bit          exp_we, chk_addr, in_rst;
  logic [23:0] exp_addr;
  logic [1:0]  exp_be;
  logic [15:0] exp_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_row[i] = '0; m_act[i] = 0; end
    m_mode = 13'h020; m_ref = '0; m_err = 0; m_code = '0;
    exp_dq.delete();
    exp_we = 0; chk_addr = 0;
  endtask

  task automatic model_apply(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                             input logic [1:0] dm, input logic [15:0] din);
    int          code;
    int          cl;
    bit          any_open;
    logic [23:0] ad24;
    code = 0; exp_we = 0; chk_addr = 0;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    cl = int'(m_mode[6:4]);
    if (!c[3]) begin
      case (c[2:0])
        3'b011: if (m_open[b]) code = 1;
                else begin m_open[b] = 1; m_row[b] = ad; m_act[b] = cyc; end
        3'b101, 3'b100: begin
          ad24 = {b, m_row[b], ad[8:0]};
          if (!m_open[b])                             code = 2;
          else if (c[2:0] == 3'b101 && cl != 2 && cl != 3) code = 5;
          else if (cyc - m_act[b] < TRCD)             code = 3;
          if (c[2:0] == 3'b100) begin
            exp_we = (dm != 2'b11); chk_addr = exp_we;
            exp_addr = ad24; exp_be = ~dm; exp_wd = din;
          end else if (code == 0 || code == 3) begin
            chk_addr = 1; exp_addr = ad24;
            if (dm != 2'b11) exp_dq[cyc + cl] = mem_fn(ad24);
          end
        end
        3'b010: if (ad[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                else m_open[b] = 0;
        3'b001: if (any_open) code = 4; else m_ref = m_ref + 16'd1;
        3'b000: if (any_open) code = 4;
                else begin m_mode = ad; if (ad[2:0] != 3'b000) code = 6; end
        default: ;
      endcase
    end
    if (!m_err && code != 0) begin m_err = 1; m_code = 3'(code); end
  endtask

  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                      input logic [1:0] dm, input logic [15:0] din, input bit rst);
    @(negedge clk);
    reset = rst; {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; a = ad; dqm = dm; dq_in = din;
    @(posedge clk);
    cyc++;
    in_rst = rst;
    if (rst) model_reset(); else model_apply(c, b, ad, dm, din);
    #1;
    chk("mode_reg", 32'(mode_reg), 32'(m_mode));
    chk("refresh_cnt", 32'(refresh_cnt), 32'(m_ref));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("dq_oe", 32'(dq_oe), 32'(exp_dq.exists(cyc)));
    if (exp_dq.exists(cyc)) chk("dq_out", 32'(dq_out), 32'(exp_dq[cyc]));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    if (chk_addr) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_we) begin
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    end
    if (in_rst) begin
      chk("rst_dq_out", 32'(dq_out), 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(4'b0111, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) step(4'b0111, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1);
  endtask

  localparam logic [3:0] C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                         C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

  logic [12:0] mode_tbl [6] = '{13'h020, 13'h030, 13'h220, 13'h021, 13'h010, 13'h040};

  initial begin
    reset = 1'b1; {cs_n, ras_n, cas_n, we_n} = 4'b1111;
    ba = '0; a = '0; dqm = '0; dq_in = '0;
    model_reset();

    rst(3);
    step(C_LMR, 2'd0, 13'h220, 2'b00, 16'h0, 0);
    chk("d_mode", 32'(mode_reg), 32'h220);

    // write into an opened row
    step(C_ACT, 2'd1, 13'h0123, 2'b00, 16'h0, 0);
    nop(2);
    step(C_WR, 2'd1, 13'h0005, 2'b00, 16'hA5A5, 0);
    chk("d_wr_addr", 32'(mem_addr), 32'({2'd1, 13'h0123, 9'h005}));

    // CL=2 then CL=3 read of address 0 (memory returns 0x5A5A)
    step(C_ACT, 2'd0, 13'h0000, 2'b00, 16'h0, 0);
    nop(1);
    step(C_RD, 2'd0, 13'h0000, 2'b00, 16'h0, 0);
    nop(1);
    nop(1);
    chk("d_cl2_dq", 32'(dq_out), 32'h5A5A);
    nop(2);
    step(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0, 0);
    step(C_LMR, 2'd0, 13'h0230, 2'b00, 16'h0, 0);
    step(C_ACT, 2'd0, 13'h0000, 2'b00, 16'h0, 0);
    nop(1);
    step(C_RD, 2'd0, 13'h0000, 2'b00, 16'h0, 0);
    nop(5);
    // masked read: no dq_oe
    step(C_RD, 2'd0, 13'h0007, 2'b11, 16'h0, 0);
    nop(4);

    // idle-bank read, then ACTIVE-on-active must not overwrite the code
    step(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0, 0);
    step(C_LMR, 2'd0, 13'h0220, 2'b00, 16'h0, 0);
    step(C_RD, 2'd2, 13'h0011, 2'b00, 16'h0, 0);
    nop(4);
    step(C_ACT, 2'd1, 13'h0001, 2'b00, 16'h0, 0);
    step(C_ACT, 2'd1, 13'h0002, 2'b00, 16'h0, 0);
    chk("d_code2", 32'(err_code), 32'd2);

    // early read: code 3, data still returned; refresh with bank open ignored
    rst(2);
    step(C_ACT, 2'd3, 13'h0005, 2'b00, 16'h0, 0);
    step(C_RD, 2'd3, 13'h0009, 2'b00, 16'h0, 0);
    chk("d_code3", 32'(err_code), 32'd3);
    nop(3);
    step(C_REF, 2'd0, 13'h0, 2'b00, 16'h0, 0);
    chk("d_ref_open", 32'(refresh_cnt), 32'd0);

    // reset between READ and its data edge
    rst(2);
    step(C_ACT, 2'd0, 13'h0044, 2'b00, 16'h0, 0);
    nop(2);
    step(C_RD, 2'd0, 13'h0003, 2'b00, 16'h0, 0);
    rst(1);
    nop(4);

    // random command streams
    for (int seg = 0; seg < 4; seg++) begin
      rst(2);
      for (int n = 0; n < 300; n++) begin
        int          r;
        logic [1:0]  b, dm;
        logic [12:0] ad;
        logic [15:0] d;
        r  = int'($urandom_range(0, 99));
        b  = 2'($urandom_range(0, 3));
        ad = 13'($urandom);
        d  = 16'($urandom);
        dm = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        if (r < 20)      step(4'b0111, b, ad, dm, d, 0);
        else if (r < 25) step({1'b1, 3'($urandom)}, b, ad, dm, d, 0);
        else if (r < 40) step(C_ACT, b, ad, dm, d, 0);
        else if (r < 60) step(C_RD, b, ad, dm, d, 0);
        else if (r < 72) step(m_open[b] ? C_WR : 4'b0111, b, ad, dm, d, 0);
        else if (r < 84) step(C_PRE, b, ad, dm, d, 0);
        else if (r < 89) step(C_REF, b, ad, dm, d, 0);
        else if (r < 95) step(C_LMR, b, mode_tbl[$urandom_range(0, 5)], dm, d, 0);
        else             step(4'b0110, b, ad, dm, d, 0);
      end
    end

    // refresh counter wrap
    rst(2);
    for (int i = 0; i < 65535; i++) step(C_REF, 2'd0, 13'h0, 2'b00, 16'h0, 0);
    chk("d_ref_max", 32'(refresh_cnt), 32'hFFFF);
    step(C_REF, 2'd0, 13'h0, 2'b00, 16'h0, 0);
    chk("d_ref_wrap", 32'(refresh_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ROW_BITS, default 13, row address width (A bus width).
REQ-002 SHALL have parameter COL_BITS, default 9, column bits taken from A[COL_BITS-1:0].
REQ-003 SHALL have parameter TRCD, default 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset (reset reset, synchronous, active-high; clock clk).
REQ-005 SHALL have ports: cs_n, ras_n, cas_n, we_n in 1 each, SDRAM command; ba in 2 bank; a in ROW_BITS address; dqm in 2 byte masks.
REQ-006 SHALL have ports: dq_in in 16 bus data from initiator; dq_out out 16 read data; dq_oe out 1 drive enable for dq_out.
REQ-007 SHALL have ports: mem_addr out 2+ROW_BITS+COL_BITS word address {ba,row,col}; mem_we out 1; mem_be out 2; mem_wdata out 16; mem_rdata in 16, valid one cycle after mem_addr.
REQ-008 SHALL have ports: mode_reg out 13 current mode register; refresh_cnt out 16 refresh count; err out 1 sticky error; err_code out 3 first error cause.

Function
REQ-009 SHALL decode {cs_n,ras_n,cas_n,we_n} at each clk edge: 1xxx INHIBIT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE, 0110 BURST_TERMINATE (treated as NOP).
REQ-010 SHALL keep per bank state IDLE/ACTIVE plus open row; ACTIVE stores a as row, sets ACTIVE, clears that bank's TRCD counter.
REQ-011 SHALL, on PRECHARGE, idle all banks when a[10]=1, else only bank ba; precharge of an idle bank is legal, no error.
REQ-012 SHALL, on READ with command sampled at edge E, drive mem_addr={ba,row,a[COL_BITS-1:0]} after E, and present dq_out with dq_oe=1 for exactly the cycle sampled at edge E+CL, CL=mode_reg[6:4].
REQ-013 SHALL hold dq_oe=0 in that data cycle when dqm at the READ edge was 2'b11; otherwise dq_oe=1, dq_out=mem_rdata.
REQ-014 SHALL, on WRITE sampled at edge E, assert mem_we for the cycle after E with mem_wdata=dq_in, mem_be=~dqm; dqm=11 gives mem_we=0.
REQ-015 SHALL support overlapping READs issued every cycle via a CL-deep pipeline; a WRITE never disturbs an in-flight read slot.
REQ-016 SHALL, on AUTO_REFRESH with all banks idle, increment refresh_cnt, wrapping 0xFFFF->0.
REQ-017 SHALL, on LOAD_MODE with all banks idle, load mode_reg <= a[12:0].
REQ-018 SHALL set err and latch err_code only when err was 0: 1 ACTIVE on active bank; 2 READ/WRITE on idle bank; 3 READ/WRITE before TRCD elapsed; 4 REFRESH/LOAD_MODE with a bank active; 5 READ with CL not 2 or 3; 6 LOAD_MODE with burst length a[2:0]!=000.
REQ-019 SHALL still perform a READ/WRITE that raised code 3; SHALL ignore ACTIVE error 1 (row unchanged), REQ-016/017 actions under code 4, and READ data under codes 2 and 5 (dq_oe stays 0).
REQ-020 SHALL treat cs_n=1 as no command regardless of other pins.

Reset
REQ-021 SHALL, while reset=1: all banks IDLE, mode_reg=13'h020 (CL=2), refresh_cnt=0, err=0, err_code=0, dq_oe=0, dq_out=0, mem_we=0, mem_be=0, read pipeline flushed.
REQ-022 SHALL drop any read or write in flight when reset asserts mid-operation; no dq_oe or mem_we pulse after reset.

Structure
REQ-023 SHALL place command encodings, err_code values, bank state enum in shared package sdram_pkg, common with the SDRAM controller.
REQ-024 SHALL use one sub-module sdram_rd_pipe (CL-deep valid/dqm shift register with dq_out register); bank tracking stays in the top.

Verification
REQ-025 SHALL cover: reset, LOAD_MODE a=13'h220 -> mode_reg=13'h220, err=0.
REQ-026 SHALL cover: ACTIVE ba=1 row 0x0123; 2 NOPs... WRITE col 0x05 dq_in=0xA5A5 dqm=00 -> mem_we=1, mem_addr={1,0x0123,0x05}, mem_be=11.
REQ-027 SHALL cover: ACTIVE, TRCD wait, READ CL=2 with mem_rdata=0x5A5A -> dq_oe=1, dq_out=0x5A5A at edge E+2 only; repeat CL=3 -> edge E+3.
REQ-028 SHALL cover: READ on idle bank 2 -> err=1, err_code=2, dq_oe never 1; a later ACTIVE-on-active leaves err_code=2.
REQ-029 SHALL cover: ACTIVE then READ one cycle later -> err_code=3, data still returned; AUTO_REFRESH with bank open -> refresh_cnt unchanged.
REQ-030 SHALL cover: refresh_cnt=0xFFFF, AUTO_REFRESH all idle -> 0x0000; reset asserted between READ and data edge -> no dq_oe.
